// File: rtl/altera_tse_gxb_rx_reset_sequencer_if.sv
// rtl/altera_tse_gxb_rx_reset_sequencer_if.sv - status/reset bundle between GXB RX channel, PCS and the reset sequencer
interface altera_tse_gxb_rx_reset_sequencer_if;
  logic       pll_locked;
  logic       rx_freqlocked;
  logic       rx_sync;
  logic       restart_req;
  logic       rx_analogreset;
  logic       rx_digitalreset;
  logic       pcs_reset;
  logic       link_ready;
  logic [7:0] resync_count;
  logic [2:0] seq_state;

  modport master (
    input  pll_locked, rx_freqlocked, rx_sync, restart_req,
    output rx_analogreset, rx_digitalreset, pcs_reset, link_ready, resync_count, seq_state
  );

  modport slave (
    output pll_locked, rx_freqlocked, rx_sync, restart_req,
    input  rx_analogreset, rx_digitalreset, pcs_reset, link_ready, resync_count, seq_state
  );
endinterface

// File: rtl/altera_tse_gxb_rx_reset_sequencer.sv
// rtl/altera_tse_gxb_rx_reset_sequencer.sv - GXB RX analog/digital reset and link bring-up sequencer
// Optional TSE_RX_SEQ_SYNC_DEBOUNCE_EN: LINK_UP ignores rx_sync dropouts shorter than 4 cycles.
module altera_tse_gxb_rx_reset_sequencer #(
  parameter int ANALOG_RESET_CYCLES = 16,
  parameter int LOCK_WAIT_CYCLES    = 1000,
  parameter int SYNC_TIMEOUT_CYCLES = 65535,
  parameter int CNT_WIDTH           = 17
) (
  input  logic clk,
  input  logic reset,
  altera_tse_gxb_rx_reset_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    ANALOG_RST    = 3'd0,
    WAIT_FREQLOCK = 3'd1,
    WAIT_SYNC     = 3'd2,
    LINK_UP       = 3'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] ANALOG_LAST = CNT_WIDTH'(ANALOG_RESET_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LOCK_LAST   = CNT_WIDTH'(LOCK_WAIT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] SYNC_LAST   = CNT_WIDTH'(SYNC_TIMEOUT_CYCLES - 1);

  state_t               state, state_n;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 cnt_clr, cnt_inc, bump;
  logic                 pll_m, pll_locked_s, freq_m, freqlocked_s;
  logic                 analog_q, digital_q, pcs_q, ready_q;
  logic [7:0]           resync_q;
`ifdef TSE_RX_SEQ_SYNC_DEBOUNCE_EN
  logic [1:0]           drop_cnt, drop_n;
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {pll_locked_s, pll_m}  <= 2'b00;
      {freqlocked_s, freq_m} <= 2'b00;
    end else begin
      {pll_locked_s, pll_m}  <= {pll_m, bus.pll_locked};
      {freqlocked_s, freq_m} <= {freq_m, bus.rx_freqlocked};
    end
  end

  always_comb begin
    state_n = state;
    cnt_clr = 1'b0;
    cnt_inc = 1'b0;
    bump    = 1'b0;
`ifdef TSE_RX_SEQ_SYNC_DEBOUNCE_EN
    drop_n  = 2'd0;
`endif
    case (state)
      ANALOG_RST: begin
        if (pll_locked_s) begin
          cnt_inc = 1'b1;
          if (cnt == ANALOG_LAST) state_n = WAIT_FREQLOCK;
        end else begin
          cnt_clr = 1'b1;
        end
      end
      WAIT_FREQLOCK: begin
        if (!pll_locked_s) state_n = ANALOG_RST;
        else if (!freqlocked_s) cnt_clr = 1'b1;
        else begin
          cnt_inc = 1'b1;
          if (cnt == LOCK_LAST) state_n = WAIT_SYNC;
        end
      end
      WAIT_SYNC: begin
        cnt_inc = 1'b1;
        if (!pll_locked_s || !freqlocked_s) begin
          state_n = ANALOG_RST;
          bump    = 1'b1;
        end else if (!bus.rx_sync && cnt == SYNC_LAST) begin
          state_n = ANALOG_RST;
          bump    = 1'b1;
        end else if (bus.rx_sync) begin
          state_n = LINK_UP;
        end
      end
      LINK_UP: begin
        cnt_inc = 1'b1;
        if (!pll_locked_s || !freqlocked_s) begin
          state_n = ANALOG_RST;
          bump    = 1'b1;
        end else if (!bus.rx_sync) begin
`ifdef TSE_RX_SEQ_SYNC_DEBOUNCE_EN
          if (drop_cnt == 2'd3) state_n = WAIT_SYNC;
          else drop_n = drop_cnt + 2'd1;
`else
          state_n = WAIT_SYNC;
`endif
        end
      end
      default: state_n = ANALOG_RST;
    endcase
    // A software restart wins over everything and is never counted as a resync.
    if (bus.restart_req) begin
      state_n = ANALOG_RST;
      bump    = 1'b0;
      cnt_clr = 1'b1;
    end
    if (state_n != state) cnt_clr = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ANALOG_RST;
      cnt       <= '0;
      analog_q  <= 1'b1;
      digital_q <= 1'b1;
      pcs_q     <= 1'b1;
      ready_q   <= 1'b0;
      resync_q  <= 8'd0;
    end else begin
      state     <= state_n;
      if (cnt_clr) cnt <= '0;
      else if (cnt_inc && cnt != '1) cnt <= cnt + CNT_WIDTH'(1);
      analog_q  <= (state_n == ANALOG_RST);
      digital_q <= (state_n == ANALOG_RST) || (state_n == WAIT_FREQLOCK);
      pcs_q     <= (state_n == ANALOG_RST) || (state_n == WAIT_FREQLOCK);
      ready_q   <= (state_n == LINK_UP);
      if (bump && resync_q != 8'hFF) resync_q <= resync_q + 8'd1;
    end
  end

`ifdef TSE_RX_SEQ_SYNC_DEBOUNCE_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) drop_cnt <= 2'd0;
    else       drop_cnt <= drop_n;
  end
`endif

  assign bus.rx_analogreset  = analog_q;
  assign bus.rx_digitalreset = digital_q;
  assign bus.pcs_reset       = pcs_q;
  assign bus.link_ready      = ready_q;
  assign bus.resync_count    = resync_q;
  assign bus.seq_state       = state;

endmodule

// File: tb/tb_altera_tse_gxb_rx_reset_sequencer.sv
// tb/tb_altera_tse_gxb_rx_reset_sequencer.sv - self-checking bench for the GXB RX reset sequencer
module tb_altera_tse_gxb_rx_reset_sequencer;
  localparam int AR = 4;
  localparam int LW = 8;
  localparam int ST = 20;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  altera_tse_gxb_rx_reset_sequencer_if bus();

  altera_tse_gxb_rx_reset_sequencer #(
    .ANALOG_RESET_CYCLES(AR), .LOCK_WAIT_CYCLES(LW),
    .SYNC_TIMEOUT_CYCLES(ST), .CNT_WIDTH(17)
  ) dut (.clk(clk), .reset(reset), .bus(bus));

  int checks = 0;
  int errors = 0;
  int exp_q[$];

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    bus.pll_locked = 1'b1;
    bus.rx_freqlocked = 1'b1;
    bus.rx_sync = 1'b0;
    bus.restart_req = 1'b0;
    step(2);
    reset = 1'b0;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget && !ok; i++) begin
      if (bus.seq_state == s) ok = 1'b1;
      else step(1);
    end
    if (!ok && bus.seq_state == s) ok = 1'b1;
  endtask

  task automatic pop_count(input string name);
    int e;
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, resync_count=%0d", name, bus.resync_count);
    end else begin
      e = exp_q.pop_front();
      if (bus.resync_count !== 8'(e)) begin
        errors++;
        $display("FAIL %s: resync_count=%0d expected %0d", name, bus.resync_count, e);
      end
    end
  endtask

  task automatic bring_up(output bit ok);
    apply_reset();
    wait_state(3'd2, 60, ok);
    bus.rx_sync = 1'b1;
    step(1);
    if (bus.seq_state != 3'd3) ok = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.pll_locked = 1'b0;
    bus.rx_freqlocked = 1'b0;
    bus.rx_sync = 1'b0;
    bus.restart_req = 1'b0;
    step(2);
    checks++;
    if ({bus.rx_analogreset, bus.rx_digitalreset, bus.pcs_reset} !== 3'b111) begin
      errors++;
      $display("FAIL reset_resets: got %b expected 111", {bus.rx_analogreset, bus.rx_digitalreset, bus.pcs_reset});
    end
    checks++;
    if (bus.link_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: got %b expected 0", bus.link_ready);
    end
    checks++;
    if (bus.resync_count !== 8'd0 || bus.seq_state !== 3'd0) begin
      errors++;
      $display("FAIL reset_count_state: count=%0d state=%0d expected 0/0", bus.resync_count, bus.seq_state);
    end
  endtask

  task automatic test_bringup();
    apply_reset();
    step(AR + 1);
    checks++;
    if (bus.rx_analogreset !== 1'b1) begin
      errors++;
      $display("FAIL bringup_analog_hold: analog=%b expected 1 after edge %0d", bus.rx_analogreset, AR + 1);
    end
    step(1);
    checks++;
    if (bus.rx_analogreset !== 1'b0 || bus.seq_state !== 3'd1 || bus.rx_digitalreset !== 1'b1) begin
      errors++;
      $display("FAIL bringup_analog_release: analog=%b digital=%b state=%0d expected 0/1/1",
               bus.rx_analogreset, bus.rx_digitalreset, bus.seq_state);
    end
    step(LW - 1);
    checks++;
    if (bus.rx_digitalreset !== 1'b1) begin
      errors++;
      $display("FAIL bringup_digital_hold: digital=%b expected 1", bus.rx_digitalreset);
    end
    step(1);
    checks++;
    if (bus.rx_digitalreset !== 1'b0 || bus.pcs_reset !== 1'b0 || bus.seq_state !== 3'd2 || bus.link_ready !== 1'b0) begin
      errors++;
      $display("FAIL bringup_digital_release: digital=%b pcs=%b state=%0d ready=%b expected 0/0/2/0",
               bus.rx_digitalreset, bus.pcs_reset, bus.seq_state, bus.link_ready);
    end
    bus.rx_sync = 1'b1;
    step(1);
    checks++;
    if (bus.link_ready !== 1'b1 || bus.seq_state !== 3'd3) begin
      errors++;
      $display("FAIL bringup_link_up: ready=%b state=%0d expected 1/3", bus.link_ready, bus.seq_state);
    end
  endtask

  task automatic test_freqlock_glitch();
    apply_reset();
    step(AR + 2);
    step(3);
    bus.rx_freqlocked = 1'b0;
    step(1);
    bus.rx_freqlocked = 1'b1;
    step(9);
    checks++;
    if (bus.rx_digitalreset !== 1'b1 || bus.seq_state !== 3'd1) begin
      errors++;
      $display("FAIL glitch_restart: digital=%b state=%0d expected 1/1", bus.rx_digitalreset, bus.seq_state);
    end
    step(1);
    checks++;
    if (bus.rx_digitalreset !== 1'b0 || bus.seq_state !== 3'd2) begin
      errors++;
      $display("FAIL glitch_release: digital=%b state=%0d expected 0/2", bus.rx_digitalreset, bus.seq_state);
    end
  endtask

  task automatic test_lock_loss();
    bit ok;
    bring_up(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL lockloss_bringup: state=%0d expected 3", bus.seq_state);
    end
    bus.pll_locked = 1'b0;
    exp_q.push_back(1);
    step(2);
    checks++;
    if (bus.link_ready !== 1'b1 || bus.seq_state !== 3'd3) begin
      errors++;
      $display("FAIL lockloss_sync_delay: ready=%b state=%0d expected 1/3", bus.link_ready, bus.seq_state);
    end
    step(1);
    checks++;
    if (bus.link_ready !== 1'b0 || bus.seq_state !== 3'd0 || bus.rx_analogreset !== 1'b1) begin
      errors++;
      $display("FAIL lockloss_analog: ready=%b state=%0d analog=%b expected 0/0/1",
               bus.link_ready, bus.seq_state, bus.rx_analogreset);
    end
    pop_count("lockloss_count");
    bus.pll_locked = 1'b1;
    bus.rx_sync = 1'b0;
    wait_state(3'd2, 60, ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL restart_reach_wait_sync: state=%0d expected 2", bus.seq_state);
    end
    step(ST - 1);
    bus.restart_req = 1'b1;
    exp_q.push_back(1);
    step(1);
    bus.restart_req = 1'b0;
    checks++;
    if (bus.seq_state !== 3'd0 || bus.rx_analogreset !== 1'b1) begin
      errors++;
      $display("FAIL restart_timeout_state: state=%0d analog=%b expected 0/1", bus.seq_state, bus.rx_analogreset);
    end
    pop_count("restart_timeout_count");
  endtask

  task automatic test_sync_dropout();
    bit ok;
    bring_up(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL dropout_bringup: state=%0d expected 3", bus.seq_state);
    end
    bus.rx_sync = 1'b0;
    step(1);
`ifdef TSE_RX_SEQ_SYNC_DEBOUNCE_EN
    checks++;
    if (bus.link_ready !== 1'b1 || bus.seq_state !== 3'd3) begin
      errors++;
      $display("FAIL dropout1_debounced: ready=%b state=%0d expected 1/3", bus.link_ready, bus.seq_state);
    end
`else
    checks++;
    if (bus.link_ready !== 1'b0 || bus.seq_state !== 3'd2) begin
      errors++;
      $display("FAIL dropout1_immediate: ready=%b state=%0d expected 0/2", bus.link_ready, bus.seq_state);
    end
`endif
    step(2);
`ifdef TSE_RX_SEQ_SYNC_DEBOUNCE_EN
    checks++;
    if (bus.link_ready !== 1'b1) begin
      errors++;
      $display("FAIL dropout3_debounced: ready=%b expected 1", bus.link_ready);
    end
`endif
    bus.rx_sync = 1'b1;
    step(1);
    checks++;
    if (bus.link_ready !== 1'b1 || bus.seq_state !== 3'd3) begin
      errors++;
      $display("FAIL dropout_recover: ready=%b state=%0d expected 1/3", bus.link_ready, bus.seq_state);
    end
    bus.rx_sync = 1'b0;
    step(3);
`ifdef TSE_RX_SEQ_SYNC_DEBOUNCE_EN
    checks++;
    if (bus.link_ready !== 1'b1) begin
      errors++;
      $display("FAIL dropout4_pre: ready=%b expected 1", bus.link_ready);
    end
`endif
    step(1);
    checks++;
    if (bus.link_ready !== 1'b0 || bus.seq_state !== 3'd2) begin
      errors++;
      $display("FAIL dropout4_exit: ready=%b state=%0d expected 0/2", bus.link_ready, bus.seq_state);
    end
    checks++;
    if (bus.resync_count !== 8'd0) begin
      errors++;
      $display("FAIL dropout_no_count: resync_count=%0d expected 0", bus.resync_count);
    end
  endtask

  task automatic test_timeout_saturate();
    bit ok;
    apply_reset();
    wait_state(3'd2, 60, ok);
    step(ST - 1);
    checks++;
    if (bus.rx_analogreset !== 1'b0 || bus.seq_state !== 3'd2) begin
      errors++;
      $display("FAIL timeout_hold: analog=%b state=%0d expected 0/2", bus.rx_analogreset, bus.seq_state);
    end
    exp_q.push_back(1);
    step(1);
    checks++;
    if (bus.rx_analogreset !== 1'b1 || bus.seq_state !== 3'd0) begin
      errors++;
      $display("FAIL timeout_fire: analog=%b state=%0d expected 1/0", bus.rx_analogreset, bus.seq_state);
    end
    pop_count("timeout_first_count");
    for (int it = 2; it <= 300; it++) begin
      exp_q.push_back(it > 255 ? 255 : it);
      wait_state(3'd2, 60, ok);
      if (ok) wait_state(3'd0, ST + 5, ok);
      if (!ok) begin
        checks++;
        errors++;
        $display("FAIL timeout_loop: iteration %0d stuck in state %0d", it, bus.seq_state);
        exp_q.delete();
        break;
      end
      pop_count("timeout_loop_count");
    end
  endtask

  task automatic test_async_reset();
    bit ok;
    apply_reset();
    wait_state(3'd2, 60, ok);
    wait_state(3'd0, ST + 5, ok);
    wait_state(3'd2, 60, ok);
    checks++;
    if (!ok || bus.resync_count !== 8'd1) begin
      errors++;
      $display("FAIL areset_setup: state=%0d count=%0d expected 2/1", bus.seq_state, bus.resync_count);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.rx_analogreset, bus.rx_digitalreset, bus.pcs_reset, bus.link_ready} !== 4'b1110 ||
        bus.resync_count !== 8'd0 || bus.seq_state !== 3'd0) begin
      errors++;
      $display("FAIL areset_values: resets/ready=%b count=%0d state=%0d expected 1110/0/0",
               {bus.rx_analogreset, bus.rx_digitalreset, bus.pcs_reset, bus.link_ready},
               bus.resync_count, bus.seq_state);
    end
    step(1);
    reset = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_bringup();
    test_freqlock_glitch();
    test_lock_loss();
    test_sync_dropout();
    test_timeout_saturate();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
